// File: rtl/n2t_pkg.sv
// ----------------------------------------------------------------------------
// n2t_pkg
//   Shared definitions for the program counter and its return stack.
//
//   Contents:
//     DefWidth   - default counter/data width in bits (16)
//     DefDepth   - default number of return-stack entries (8)
//     req_e      - encoding of the single request that acts in a cycle
//     decode_req - fixed-priority reduction of the raw request lines
//                  (clr > ret > call > load > inc > hold)
// ----------------------------------------------------------------------------
package n2t_pkg;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefDepth = 8;

    // Larger code means higher priority; only one request acts per cycle.
    typedef enum logic [2:0] {
        ReqHold = 3'd0,
        ReqInc  = 3'd1,
        ReqLoad = 3'd2,
        ReqCall = 3'd3,
        ReqRet  = 3'd4,
        ReqClr  = 3'd5
    } req_e;

    function automatic req_e decode_req(
        input logic clr,
        input logic ret,
        input logic call,
        input logic load,
        input logic inc
    );
        req_e req;
        if (clr) begin
            req = ReqClr;
        end else if (ret) begin
            req = ReqRet;
        end else if (call) begin
            req = ReqCall;
        end else if (load) begin
            req = ReqLoad;
        end else if (inc) begin
            req = ReqInc;
        end else begin
            req = ReqHold;
        end
        return req;
    endfunction

endpackage

// File: rtl/pc_stack.sv
// ----------------------------------------------------------------------------
// pc_stack
//   LIFO holding return addresses for prog_counter. Storage is not reset;
//   only the occupancy counter is. Entries at or above the occupancy are
//   stale and are never selected onto top_data while the stack is non-empty.
//
//   Parameters:
//     WIDTH - entry width in bits
//     DEPTH - number of entries
//
//   Ports:
//     clk       - clock, rising edge
//     rst_n     - asynchronous active-low reset (clears occupancy)
//     clr       - synchronous clear of occupancy (wins over push/pop)
//     push      - write push_data at the current top (ignored when full)
//     pop       - discard the top entry (ignored when empty, wins over push)
//     push_data - value to push
//     top_data  - entry at depth-1 (meaningless when empty)
//     depth     - current occupancy
//     full      - depth == DEPTH
//     empty     - depth == 0
// ----------------------------------------------------------------------------
module pc_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             top_data,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);

    // Address width has a floor of 1 so DEPTH=1 still yields a legal index.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] FullCount = DW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    depth_d;
    logic [DW-1:0]    top_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (depth_q == FullCount);
    assign empty   = (depth_q == '0);
    assign do_pop  = pop & ~empty & ~clr;
    assign do_push = push & ~full & ~pop & ~clr;

    always_comb begin
        depth_d = depth_q;
        if (clr) begin
            depth_d = '0;
        end else if (do_pop) begin
            depth_d = depth_q - DW'(1);
        end else if (do_push) begin
            depth_d = depth_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // A push only happens below FullCount, so the low AW bits address a real entry.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[depth_q[AW-1:0]] <= push_data;
        end
    end

    assign top_idx  = depth_q - DW'(1);
    assign top_data = mem_q[top_idx[AW-1:0]];
    assign depth    = depth_q;

endmodule

// File: rtl/prog_counter.sv
// ----------------------------------------------------------------------------
// prog_counter
//   Registered program counter with clear, load, increment and an optional
//   call/return stack. Exactly one request acts per cycle, chosen by fixed
//   priority clr > ret > call > load > inc > hold. Results appear on out one
//   cycle after the sampling edge.
//
//   Build option:
//     PROG_COUNTER_STACK_EN - when defined, instantiates pc_stack and enables
//                             call/ret with sticky overflow/underflow flags.
//                             When undefined, call acts as load, ret acts as
//                             hold, and the stack outputs are tied off
//                             (depth=0, empty=1, full=ovf_err=unf_err=0).
//
//   Parameters:
//     WIDTH - counter and data width (2..32)
//     DEPTH - return-stack entries (1..64)
//
//   Ports:
//     clk     - clock, rising edge
//     rst_n   - asynchronous active-low reset
//     in      - load / call target
//     clr     - synchronous clear of counter, stack and flags
//     load    - out <= in
//     inc     - out <= out + 1 (wraps)
//     call    - push out + 1, out <= in
//     ret     - out <= popped address
//     out     - registered counter value
//     depth   - stack occupancy
//     full    - depth == DEPTH
//     empty   - depth == 0
//     ovf_err - sticky: call attempted on a full stack
//     unf_err - sticky: ret attempted on an empty stack
// ----------------------------------------------------------------------------
module prog_counter
    import n2t_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             in,
    input  logic                         clr,
    input  logic                         load,
    input  logic                         inc,
    input  logic                         call,
    input  logic                         ret,
    output logic [WIDTH-1:0]             out,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf_err,
    output logic                         unf_err
);

    req_e             req;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_inc;

    assign req     = decode_req(clr, ret, call, load, inc);
    assign out_inc = out_q + WIDTH'(1);

`ifdef PROG_COUNTER_STACK_EN

    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic             stk_clr;
    logic             stk_push;
    logic             stk_pop;
    logic             stk_full;
    logic             stk_empty;
    logic [WIDTH-1:0] stk_top;
    logic [DW-1:0]    stk_depth;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;

    pc_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (stk_clr),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (out_inc),
        .top_data  (stk_top),
        .depth     (stk_depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        out_d    = out_q;
        stk_clr  = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        unique case (req)
            ReqClr: begin
                out_d   = '0;
                stk_clr = 1'b1;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end
            ReqRet: begin
                if (stk_empty) begin
                    unf_d = 1'b1;
                end else begin
                    out_d   = stk_top;
                    stk_pop = 1'b1;
                end
            end
            ReqCall: begin
                if (stk_full) begin
                    ovf_d = 1'b1;
                end else begin
                    out_d    = in;
                    stk_push = 1'b1;
                end
            end
            ReqLoad: out_d = in;
            ReqInc:  out_d = out_inc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign depth   = stk_depth;
    assign full    = stk_full;
    assign empty   = stk_empty;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

`else

    // Without a stack, call degenerates to load and ret to hold.
    always_comb begin
        out_d = out_q;
        unique case (req)
            ReqClr:           out_d = '0;
            ReqCall, ReqLoad: out_d = in;
            ReqInc:           out_d = out_inc;
            default:          ;
        endcase
    end

    assign depth   = '0;
    assign full    = 1'b0;
    assign empty   = 1'b1;
    assign ovf_err = 1'b0;
    assign unf_err = 1'b0;

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_prog_counter.sv
module tb_prog_counter;

    localparam int unsigned W = 16;
    localparam int unsigned D = 8;
`ifdef PROG_COUNTER_STACK_EN
    localparam bit StackOn = 1'b1;
`else
    localparam bit StackOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_v;
    logic        clr, load, inc, call, ret;
    logic [15:0] out;
    logic [3:0]  depth;
    logic        full, empty, ovf_err, unf_err;

    prog_counter #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in_v),
        .clr     (clr),
        .load    (load),
        .inc     (inc),
        .call    (call),
        .ret     (ret),
        .out     (out),
        .depth   (depth),
        .full    (full),
        .empty   (empty),
        .ovf_err (ovf_err),
        .unf_err (unf_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: counter value, return stack as a queue, sticky flags.
    int unsigned m_out;
    int unsigned m_stk[$];
    bit          m_ovf;
    bit          m_unf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_out = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input bit c_clr, input bit c_ret, input bit c_call,
                              input bit c_load, input bit c_inc, input int unsigned v);
        if (c_clr) begin
            model_reset();
        end else if (c_ret) begin
`ifdef PROG_COUNTER_STACK_EN
            if (m_stk.size() == 0) m_unf = 1'b1;
            else m_out = m_stk.pop_back();
`endif
        end else if (c_call) begin
`ifdef PROG_COUNTER_STACK_EN
            if (m_stk.size() == D) m_ovf = 1'b1;
            else begin
                m_stk.push_back((m_out + 1) % (1 << W));
                m_out = v;
            end
`else
            m_out = v;
`endif
        end else if (c_load) begin
            m_out = v;
        end else if (c_inc) begin
            m_out = (m_out + 1) % (1 << W);
        end
    endtask

    // Single compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        check("out",     out,     m_out);
        check("depth",   depth,   m_stk.size());
        check("full",    full,    m_stk.size() == D);
        check("empty",   empty,   m_stk.size() == 0);
        check("ovf_err", ovf_err, m_ovf);
        check("unf_err", unf_err, m_unf);
    end

    // One clock: drive at the falling edge, model steps at the rising edge.
    task automatic cyc(input bit c_clr, input bit c_ret, input bit c_call,
                       input bit c_load, input bit c_inc, input logic [15:0] v);
        clr  = c_clr;
        ret  = c_ret;
        call = c_call;
        load = c_load;
        inc  = c_inc;
        in_v = v;
        @(posedge clk);
        model_step(c_clr, c_ret, c_call, c_load, c_inc, v);
        @(negedge clk);
    endtask

    initial begin
        {clr, ret, call, load, inc} = 5'b0;
        in_v  = 16'h0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_out",   out,   16'h0);
        check("rst_async_empty", empty, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_out", out, 16'h0);
        rst_n = 1'b1;

        // Increment after reset release.
        cyc(0, 0, 0, 0, 1, 16'h0); check("inc1", out, 16'h0001);
        cyc(0, 0, 0, 0, 1, 16'h0); check("inc2", out, 16'h0002);
        cyc(0, 0, 0, 0, 1, 16'h0); check("inc3", out, 16'h0003);

        // Wraparound without flags.
        cyc(0, 0, 0, 1, 0, 16'hFFFE); check("wrap_load", out, 16'hFFFE);
        cyc(0, 0, 0, 0, 1, 16'h0);    check("wrap_ffff", out, 16'hFFFF);
        cyc(0, 0, 0, 0, 1, 16'h0);    check("wrap_zero", out, 16'h0000);
        check("wrap_flags", {ovf_err, unf_err}, 2'b00);

        // Load beats inc.
        cyc(0, 0, 0, 1, 1, 16'h5555); check("load_over_inc", out, 16'h5555);

        // Call then return.
        cyc(0, 0, 0, 1, 0, 16'h0010);
        cyc(0, 0, 1, 0, 0, 16'h0100);
        check("call_out",   out,   16'h0100);
        check("call_depth", depth, StackOn ? 4'd1 : 4'd0);
        cyc(0, 1, 0, 0, 0, 16'h0);
        check("ret_out",   out,   StackOn ? 16'h0011 : 16'h0100);
        check("ret_depth", depth, 4'd0);

        // Simultaneous call and ret: ret only, no overflow.
        cyc(0, 0, 0, 1, 0, 16'h0200);
        cyc(0, 0, 1, 0, 0, 16'h0300);
        cyc(0, 1, 1, 0, 0, 16'h0999);
        check("callret_out", out,     StackOn ? 16'h0201 : 16'h0300);
        check("callret_ovf", ovf_err, 1'b0);

        // Fill the stack, overflow once, then unwind in LIFO order.
        cyc(0, 0, 0, 1, 0, 16'h0000);
        for (int k = 0; k < 8; k++) cyc(0, 0, 1, 0, 0, 16'h1000 + 16'(k * 16));
        check("fill_full", full, StackOn);
        cyc(0, 0, 1, 0, 0, 16'h0555);
        check("ovf_out",  out,     StackOn ? 16'h1070 : 16'h0555);
        check("ovf_flag", ovf_err, StackOn);
        for (int j = 0; j < 8; j++) begin
            cyc(0, 1, 0, 0, 0, 16'h0);
            check("lifo_ret", out,
                  !StackOn ? 16'h0555 : (j < 7) ? 16'h1061 - 16'(j * 16) : 16'h0001);
        end
        check("lifo_ovf_sticky", ovf_err, StackOn);

        // Reset mid-cycle with inc pending; first edge after release acts.
        {clr, ret, call, load, inc} = 5'b00001;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_out", out,     16'h0);
        check("midrst_ovf", ovf_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 1, 0, 16'h0ABC); check("post_rst_load", out, 16'h0ABC);

        // Underflow, legal ops still execute, clr clears flags.
        cyc(0, 0, 0, 1, 0, 16'h0123);
        cyc(0, 1, 0, 0, 0, 16'h0);
        check("unf_out",  out,     16'h0123);
        check("unf_flag", unf_err, StackOn);
        cyc(0, 0, 0, 0, 1, 16'h0); check("unf_then_inc", out, 16'h0124);
        cyc(1, 0, 0, 0, 0, 16'h0);
        check("clr_out", out,     16'h0);
        check("clr_unf", unf_err, 1'b0);

        // Everything at once with depth 2: clr wins.
        cyc(0, 0, 1, 0, 0, 16'h0A00);
        cyc(0, 0, 1, 0, 0, 16'h0B00);
        check("pre_all_depth", depth, StackOn ? 4'd2 : 4'd0);
        cyc(1, 1, 1, 1, 1, 16'h7777);
        check("all_out",   out,   16'h0);
        check("all_depth", depth, 4'd0);
        cyc(0, 0, 1, 0, 0, 16'h0042);
        check("call42_out",   out,   16'h0042);
        check("call42_depth", depth, StackOn ? 4'd1 : 4'd0);

        cyc(0, 0, 0, 0, 0, 16'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
